mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single physical memory port (dev_mem_*) between the IF-stage
//  instruction fetch path and the MEM-stage data path.
//  Sits between the mmu request sources and the physical memory controller.
//  Data port has priority; a streak counter guarantees instruction fetches
//  cannot be starved indefinitely.
//  Sequences each access as issue -> wait-on-busy -> one-cycle ready pulse.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive data grants while instr_req is pending, after which the next grant goes to instr (1..15)
// PORTS
//  clk             in   1   system clock
//  rst             in   1   synchronous reset, active high
//  instr_req       in   1   fetch request; held high until instr_ready
//  instr_addr      in   32  fetch address; stable while instr_req is high
//  instr_data      out  32  fetched word; valid while instr_ready=1, held after
//  instr_ready     out  1   one-cycle completion pulse for fetch
//  data_req        in   1   data request; held high until data_ready
//  data_is_write   in   1   1=write, 0=read; stable while data_req is high
//  data_addr       in   32  data address; stable while data_req is high
//  data_wdata      in   32  write data; stable while data_req is high
//  data_rdata      out  32  read word; valid while data_ready=1, held after
//  data_ready      out  1   one-cycle completion pulse (reads and writes)
//  dev_mem_req     out  1   access in flight to physical memory
//  dev_mem_addr    out  32  latched address of granted access
//  dev_mem_data_out out 32  latched write data (0 for reads)
//  dev_mem_is_write out 1   latched direction of granted access
//  dev_mem_data_in in   32  read data from memory controller
//  dev_mem_busy    in   1   controller not yet finished with current access
//  grant_is_data   out  1   1 while the current/last grant is the data port (debug)
// BEHAVIOUR
//  Clocking and reset
//   - One clock. rst is synchronous and active high.
//   - Reset forces: state=IDLE; all outputs 0; streak counter 0.
//   - Reset during BUSY aborts the access; no ready pulse is ever produced for it.
//  FSM states: IDLE, BUSY, DONE (registered)
//   IDLE
//    - If data_req and !(instr_req && streak==STARVE_LIMIT): grant data.
//    - Else if instr_req: grant instr.
//    - On grant: latch addr, wdata, is_write and grant_is_data. Go to BUSY.
//    - With no request, remain in IDLE.
//   BUSY
//    - dev_mem_req=1. dev_mem_* are driven from the latched values only.
//    - A cycle with dev_mem_busy=0 completes the access:
//       - capture dev_mem_data_in into rdata of the granted port (reads only);
//       - go to DONE.
//    - dev_mem_busy=1 stays in BUSY. There is no timeout.
//   DONE
//    - dev_mem_req=0. The granted port's ready=1 for exactly this cycle.
//    - Requests are ignored in DONE. Always returns to IDLE.
//  Latency
//   - Request seen in IDLE at cycle N; BUSY at N+1.
//   - With busy=0 at N+1, ready=1 at N+2.
//   - Next grant is possible at N+3 (min 3 cycles per access).
//  Streak counter (4b)
//   - On a data grant with instr_req=1: +1, saturating at STARVE_LIMIT.
//   - Reset to 0 on any instr grant, or in IDLE when instr_req=0.
//  Misc
//   - The rdata of the non-granted port is never modified.
//   - Writes leave data_rdata unchanged.
//   - Simultaneous req on both ports with streak<STARVE_LIMIT: data wins. The instr request stays pending.
// TESTING
//  - Fetch only: instr_req=1, addr=0x100, busy=0, din=0xDEADBEEF -> dev_mem_req @+1, instr_ready @+2 with instr_data=0xDEADBEEF.
//  - Data write: addr=0x2000, wdata=0x12345678, busy high 3 cycles -> dev_mem_is_write=1 throughout BUSY; data_ready exactly 1 cycle after busy falls; data_rdata unchanged.
//  - Both requests in the same cycle -> data is served first; instr_ready follows the next access; no ready pulse for both in one cycle.
//  - data_req held continuously for 10 accesses with instr_req=1, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D...
//  - rst asserted mid-BUSY -> next cycle all outputs 0 and state IDLE; no ready pulse for the aborted access.
//  - Requests kept high during DONE -> no duplicate grant; exactly one ready pulse per access.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one physical memory port between instruction fetch and data accesses.
// Data has priority; a grant streak counter bounds how long a pending fetch can wait.
//
//   state  | meaning
//   IDLE   | waiting for a request; arbitration and latching happen here
//   BUSY   | access in flight, dev_mem_req high until dev_mem_busy drops
//   DONE   | one-cycle ready pulse to the granted port, requests ignored
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    output logic        instr_ready,
    input  logic        data_req,
    input  logic        data_is_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ready,
    output logic        dev_mem_req,
    output logic [31:0] dev_mem_addr,
    output logic [31:0] dev_mem_data_out,
    output logic        dev_mem_is_write,
    input  logic [31:0] dev_mem_data_in,
    input  logic        dev_mem_busy,
    output logic        grant_is_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [3:0] streak;
    logic       pick_data;

    // Data wins unless a fetch has already waited out the full streak.
    assign pick_data = data_req && !(instr_req && (streak == LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            streak           <= 4'd0;
            grant_is_data    <= 1'b0;
            dev_mem_addr     <= 32'd0;
            dev_mem_data_out <= 32'd0;
            dev_mem_is_write <= 1'b0;
            instr_data       <= 32'd0;
            data_rdata       <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_data) begin
                        state            <= S_BUSY;
                        grant_is_data    <= 1'b1;
                        dev_mem_addr     <= data_addr;
                        dev_mem_data_out <= data_is_write ? data_wdata : 32'd0;
                        dev_mem_is_write <= data_is_write;
                        if (instr_req)
                            streak <= (streak == LIMIT) ? LIMIT : streak + 4'd1;
                        else
                            streak <= 4'd0;
                    end else if (instr_req) begin
                        state            <= S_BUSY;
                        grant_is_data    <= 1'b0;
                        dev_mem_addr     <= instr_addr;
                        dev_mem_data_out <= 32'd0;
                        dev_mem_is_write <= 1'b0;
                        streak           <= 4'd0;
                    end else begin
                        streak <= 4'd0;
                    end
                end
                S_BUSY: begin
                    if (!dev_mem_busy) begin
                        state <= S_DONE;
                        if (!grant_is_data)
                            instr_data <= dev_mem_data_in;
                        else if (!dev_mem_is_write)
                            data_rdata <= dev_mem_data_in;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dev_mem_req = (state == S_BUSY);
    assign instr_ready = (state == S_DONE) && !grant_is_data;
    assign data_ready  = (state == S_DONE) && grant_is_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        instr_ready;
    logic        data_req;
    logic        data_is_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        dev_mem_req;
    logic [31:0] dev_mem_addr;
    logic [31:0] dev_mem_data_out;
    logic        dev_mem_is_write;
    logic [31:0] dev_mem_data_in;
    logic        dev_mem_busy;
    logic        grant_is_data;

    int total = 0;
    int bad   = 0;

    // Reference model state: pending requests, their payloads, streak, expected read data.
    bit          pend_i, pend_d;
    logic [31:0] cur_ia, cur_da, cur_dw;
    bit          cur_dwr;
    int          streak;
    logic [31:0] exp_idata, exp_drdata;
    logic        obs_gd;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk              (clk),
        .rst              (rst),
        .instr_req        (instr_req),
        .instr_addr       (instr_addr),
        .instr_data       (instr_data),
        .instr_ready      (instr_ready),
        .data_req         (data_req),
        .data_is_write    (data_is_write),
        .data_addr        (data_addr),
        .data_wdata       (data_wdata),
        .data_rdata       (data_rdata),
        .data_ready       (data_ready),
        .dev_mem_req      (dev_mem_req),
        .dev_mem_addr     (dev_mem_addr),
        .dev_mem_data_out (dev_mem_data_out),
        .dev_mem_is_write (dev_mem_is_write),
        .dev_mem_data_in  (dev_mem_data_in),
        .dev_mem_busy     (dev_mem_busy),
        .grant_is_data    (grant_is_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   {31'd0, dev_mem_req}, 32'd0);
        check({tag, "_addr"},  dev_mem_addr, 32'd0);
        check({tag, "_dout"},  dev_mem_data_out, 32'd0);
        check({tag, "_we"},    {31'd0, dev_mem_is_write}, 32'd0);
        check({tag, "_rdy"},   {30'd0, instr_ready, data_ready}, 32'd0);
        check({tag, "_idata"}, instr_data, 32'd0);
        check({tag, "_drdata"}, data_rdata, 32'd0);
        check({tag, "_gd"},    {31'd0, grant_is_data}, 32'd0);
    endtask

    // Raise the wanted requests (if not already pending), then follow one access
    // from grant to ready. Called on a negedge while the DUT is idle.
    task automatic run_access(input bit want_i, input bit want_d,
                              input logic [31:0] ia, input logic [31:0] da,
                              input logic [31:0] dw, input bit dwr,
                              input int nb, input logic [31:0] din);
        bit win_d;
        int n;
        if (want_i && !pend_i) begin
            pend_i = 1; cur_ia = ia;
            instr_req = 1'b1; instr_addr = ia;
        end
        if (want_d && !pend_d) begin
            pend_d = 1; cur_da = da; cur_dw = dw; cur_dwr = dwr;
            data_req = 1'b1; data_addr = da; data_wdata = dw; data_is_write = dwr;
        end
        if (!pend_i && !pend_d) begin
            @(negedge clk);
            return;
        end
        win_d = pend_d && !(pend_i && streak == LIMIT);

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dev_mem_req && n < 4);
        check("grant_latency", n, 1);
        check("grant_req", {31'd0, dev_mem_req}, 32'd1);
        obs_gd = grant_is_data;
        check("grant_port", {31'd0, grant_is_data}, {31'd0, win_d});
        check("grant_addr", dev_mem_addr, win_d ? cur_da : cur_ia);
        check("grant_we", {31'd0, dev_mem_is_write}, {31'd0, win_d && cur_dwr});
        check("grant_wdata", dev_mem_data_out, (win_d && cur_dwr) ? cur_dw : 32'd0);

        dev_mem_busy    = (nb > 0);
        dev_mem_data_in = (nb > 0) ? $urandom : din;
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            check("busy_req", {31'd0, dev_mem_req}, 32'd1);
            check("busy_we", {31'd0, dev_mem_is_write}, {31'd0, win_d && cur_dwr});
            check("busy_no_ready", {30'd0, instr_ready, data_ready}, 32'd0);
            if (k == nb - 1) begin
                dev_mem_busy    = 1'b0;
                dev_mem_data_in = din;
            end
        end

        @(negedge clk);
        check("ready_port", {30'd0, instr_ready, data_ready}, win_d ? 32'd1 : 32'd2);
        check("ready_req_low", {31'd0, dev_mem_req}, 32'd0);
        if (win_d) begin
            streak = pend_i ? ((streak + 1 > LIMIT) ? LIMIT : streak + 1) : 0;
            if (!cur_dwr) exp_drdata = din;
            pend_d = 0; data_req = 1'b0;
        end else begin
            streak = 0;
            exp_idata = din;
            pend_i = 0; instr_req = 1'b0;
        end
        check("instr_data", instr_data, exp_idata);
        check("data_rdata", data_rdata, exp_drdata);

        @(negedge clk);
        check("done_no_regrant", {29'd0, dev_mem_req, instr_ready, data_ready}, 32'd0);
    endtask

    initial begin
        logic [9:0] pat;
        rst = 1'b1;
        instr_req = 1'b0; instr_addr = '0;
        data_req = 1'b0; data_is_write = 1'b0; data_addr = '0; data_wdata = '0;
        dev_mem_data_in = '0; dev_mem_busy = 1'b0;
        pend_i = 0; pend_d = 0; streak = 0;
        cur_ia = '0; cur_da = '0; cur_dw = '0; cur_dwr = 0;
        exp_idata = '0; exp_drdata = '0; obs_gd = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Fetch only: ready two cycles after the request, with the memory word.
        run_access(1, 0, 32'h100, 32'h0, 32'h0, 0, 0, 32'hDEADBEEF);
        check("fetch_word", instr_data, 32'hDEADBEEF);

        // Data write with three busy cycles: read data must stay untouched.
        run_access(0, 1, 32'h0, 32'h2000, 32'h12345678, 1, 3, 32'hA5A5A5A5);
        check("write_keeps_rdata", data_rdata, 32'h0);

        // Data read.
        run_access(0, 1, 32'h0, 32'h3000, 32'h0, 0, 1, 32'hCAFEF00D);
        check("read_word", data_rdata, 32'hCAFEF00D);

        // Simultaneous requests: data first, then the held fetch.
        run_access(1, 1, 32'h400, 32'h4000, 32'h0, 0, 0, 32'h11112222);
        check("both_first_is_data", {31'd0, obs_gd}, 32'd1);
        run_access(0, 0, 32'h0, 32'h0, 32'h0, 0, 2, 32'h33334444);
        check("both_second_is_instr", {31'd0, obs_gd}, 32'd0);

        // Reset in the middle of a busy access aborts it silently.
        data_req = 1'b1; data_addr = 32'h5000; data_wdata = 32'h77; data_is_write = 1'b1;
        @(negedge clk);
        check("abort_granted", {31'd0, dev_mem_req}, 32'd1);
        dev_mem_busy = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0; data_req = 1'b0; dev_mem_busy = 1'b0;
        pend_i = 0; pend_d = 0; streak = 0; exp_idata = '0; exp_drdata = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_ready", {29'd0, dev_mem_req, instr_ready, data_ready}, 32'd0);
        end

        // Both held continuously: four data grants, then the fetch, repeating.
        pat = 10'b0111101111;
        for (int i = 0; i < 10; i++) begin
            run_access(1, 1, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2), $urandom);
            check("starve_order", {31'd0, obs_gd}, {31'd0, pat[i]});
        end

        // Randomized rounds against the model.
        for (int r = 0; r < 60; r++) begin
            run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
